// File: rtl/cap_touch_scanner_if.sv
// Control/status bundle of the capacitive touch scanner: recal request in, debounced buttons and health flags out.
// Pure wiring with no latency; there is no backpressure and recal is sampled every cycle.
interface cap_touch_scanner_if #(
    parameter int CHANNELS = 4
);
    logic                recal;
    logic [CHANNELS-1:0] btn;
    logic                cal_done;
    logic [CHANNELS-1:0] timeout_err;

    modport master (input recal, output btn, output cal_done, output timeout_err);
    modport slave  (output recal, input btn, input cal_done, input timeout_err);
endinterface

// File: rtl/cap_touch_scanner.sv
// Round-robin RC rise-time scanner: discharge a pad, time its rise, calibrate a baseline and debounce touches.
// btn/cal_done/timeout_err update one cycle after a pad's measure ends; there is no backpressure.
module cap_touch_scanner #(
    parameter int CHANNELS         = 4,
    parameter int CNT_W            = 15,
    parameter int DISCHARGE_CYCLES = 11,
    parameter int THRESH_SHIFT     = 3,
    parameter int DEBOUNCE         = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] cap_in,
    output wire  [CHANNELS-1:0] cap_out,
    output logic [CHANNELS-1:0] cap_oe,
    cap_touch_scanner_if.master sb
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DC_W = $clog2(DISCHARGE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DISCHARGE_CYCLES - 1);

    typedef enum logic {ST_DISCHARGE, ST_MEASURE} state_t;
    typedef enum logic {MODE_CAL, MODE_RUN} mode_t;

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DC_W-1:0]     dcnt_q, dcnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0]    base_q [CHANNELS];
    logic [DEBOUNCE-1:0] hist_q [CHANNELS];
    logic [CHANNELS-1:0] btn_q, terr_q;
    logic                cal_done_q, recal_pend_q;

    logic                smp_vld, smp_tmo, recal_act;
    logic [CNT_W-1:0]    smp_dat;
    logic [CNT_W:0]      thresh;
    logic                touched;
    logic [DEBOUNCE-1:0] hist_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_DISCHARGE;
            mode_q  <= MODE_CAL;
            ch_q    <= '0;
            dcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ch_q    <= ch_d;
            dcnt_q  <= dcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        ch_d      = ch_q;
        dcnt_d    = dcnt_q;
        cnt_d     = cnt_q;
        smp_vld   = 1'b0;
        smp_tmo   = 1'b0;
        smp_dat   = cnt_q;
        recal_act = 1'b0;
        unique case (state_q)
            ST_DISCHARGE: begin
                if (dcnt_q == DC_LAST) begin
                    state_d = ST_MEASURE;
                    dcnt_d  = '0;
                    cnt_d   = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                // A pad still low at full count is treated as stuck; the counter never wraps.
                if (sync2_q[ch_q]) begin
                    smp_vld = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    smp_vld = 1'b1;
                    smp_tmo = 1'b1;
                    smp_dat = CNT_MAX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (smp_vld) begin
                    state_d = ST_DISCHARGE;
                    dcnt_d  = '0;
                    if (recal_pend_q || sb.recal) begin
                        recal_act = 1'b1;
                        ch_d      = '0;
                        mode_d    = MODE_CAL;
                    end else begin
                        ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
                        if (mode_q == MODE_CAL && ch_q == LAST_CH) mode_d = MODE_RUN;
                    end
                end
            end
            default: state_d = ST_DISCHARGE;
        endcase
    end

    // Widened by one bit so baseline plus margin cannot overflow near full scale.
    always_comb begin
        thresh   = {1'b0, base_q[ch_q]} + {1'b0, (base_q[ch_q] >> THRESH_SHIFT)};
        touched  = ({1'b0, smp_dat} > thresh);
        hist_nxt = {hist_q[ch_q][DEBOUNCE-2:0], touched};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            btn_q        <= '0;
            terr_q       <= '0;
            cal_done_q   <= 1'b0;
            recal_pend_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                base_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            sync1_q <= cap_in;
            sync2_q <= sync1_q;
            if (recal_act)     recal_pend_q <= 1'b0;
            else if (sb.recal) recal_pend_q <= 1'b1;

            if (recal_act) begin
                cal_done_q <= 1'b0;
                terr_q     <= '0;
            end else if (smp_vld) begin
                if (smp_tmo) terr_q[ch_q] <= 1'b1;
                if (mode_q == MODE_CAL) begin
                    base_q[ch_q] <= smp_dat;
                    if (ch_q == LAST_CH) cal_done_q <= 1'b1;
                end else if (!smp_tmo) begin
                    hist_q[ch_q] <= hist_nxt;
                    if (&hist_nxt)       btn_q[ch_q] <= 1'b1;
                    else if (~|hist_nxt) btn_q[ch_q] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        cap_oe = '1;
        if (state_q == ST_MEASURE) cap_oe[ch_q] = 1'b0;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pad
        assign cap_out[g] = cap_oe[g] ? 1'b0 : 1'bz;
    end

    assign sb.btn         = btn_q;
    assign sb.cal_done    = cal_done_q;
    assign sb.timeout_err = terr_q;
endmodule

// File: tb/tb_cap_touch_scanner.sv
// Bench for cap_touch_scanner: RC pad models plus an event-level reference of calibration, threshold and debounce.
// Each finished pad measure is checked against the model; stimulus mixes directed phases and random rise times.
module tb_cap_touch_scanner;
    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int DC   = 11;
    localparam int TS   = 3;
    localparam int DB   = 4;
    localparam int MAXV = (1 << CW) - 1;
    localparam int STUCK = 1000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] cap_in = '0;
    wire  [CH-1:0] cap_out;
    logic [CH-1:0] cap_oe;

    cap_touch_scanner_if #(.CHANNELS(CH)) sb ();

    cap_touch_scanner #(
        .CHANNELS(CH), .CNT_W(CW), .DISCHARGE_CYCLES(DC), .THRESH_SHIFT(TS), .DEBOUNCE(DB)
    ) dut (
        .clk(clk), .reset(reset), .cap_in(cap_in), .cap_out(cap_out), .cap_oe(cap_oe), .sb(sb.master)
    );

    always #5 clk = ~clk;

    // Pad environment: a pad reads high once it has been released for its rise time.
    int rise[CH], rise_act[CH], rc[CH];
    // Reference: baselines, touch run-lengths and flags, updated once per finished measure.
    int            m_base[CH], run_val[CH], run_len[CH];
    logic [CH-1:0] m_btn, m_terr;
    logic          m_cal_done, m_run, m_pend;
    int            m_ch, cur_pad, gap, events;
    int            vectors = 0, miscompares = 0;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < CH; p++) begin
            m_base[p] = 0; run_val[p] = 0; run_len[p] = DB; rc[p] = 0; rise_act[p] = 0;
        end
        m_btn = '0; m_terr = '0; m_cal_done = 1'b0; m_run = 1'b0; m_pend = 1'b0;
        m_ch = 0; cur_pad = -1; gap = 0; cap_in = '0;
    endtask

    task automatic process_event(input int p);
        int  smp;
        bit  tmo, touched;
        tmo = (rise_act[p] > MAXV);
        smp = tmo ? MAXV : rise_act[p];
        check("measure_len", rc[p], smp + 1);
        if (m_pend) begin
            m_pend = 1'b0; m_ch = 0; m_run = 1'b0; m_cal_done = 1'b0; m_terr = '0;
        end else begin
            if (tmo) m_terr[p] = 1'b1;
            if (!m_run) begin
                m_base[p] = smp;
                if (p == CH - 1) begin m_cal_done = 1'b1; m_run = 1'b1; end
            end else if (!tmo) begin
                touched = (smp > m_base[p] + m_base[p] / (1 << TS));
                if (touched == run_val[p]) run_len[p]++;
                else begin run_val[p] = touched; run_len[p] = 1; end
                if (run_len[p] >= DB) m_btn[p] = run_val[p];
            end
            m_ch = (p + 1) % CH;
        end
        check("btn", sb.btn, m_btn);
        check("cal_done", sb.cal_done, m_cal_done);
        check("timeout_err", sb.timeout_err, m_terr);
        events++;
    endtask

    task automatic step();
        logic [CH-1:0] oe;
        int p;
        @(negedge clk);
        oe = cap_oe;
        if (cur_pad >= 0 && oe == '1) begin
            process_event(cur_pad);
            cur_pad = -1;
        end else if (cur_pad < 0 && oe != '1) begin
            p = 0;
            for (int i = 0; i < CH; i++) if (!oe[i]) p = i;
            check("oe_single_pad", $countones(~oe), 1);
            check("pad_order", p, m_ch);
            check("discharge_len", gap, DC);
            cur_pad = p; rise_act[p] = rise[p]; gap = 0;
        end
        if (oe == '1) gap++;
        for (int i = 0; i < CH; i++) begin
            if (oe[i]) begin rc[i] = 0; cap_in[i] = 1'b0; end
            else begin rc[i]++; cap_in[i] = (rc[i] >= rise_act[i] - 1); end
        end
    endtask

    task automatic run_events(input int n);
        int target, cyc;
        target = events + n;
        cyc = 0;
        while (events < target && cyc < n * 400) begin step(); cyc++; end
        check("event_budget", events, target);
    endtask

    task automatic wait_measure(input int p);
        int cyc;
        cyc = 0;
        while (cur_pad != p && cyc < 2000) begin step(); cyc++; end
        check("wait_pad", cur_pad, p);
    endtask

    task automatic pulse_recal();
        sb.recal = 1'b1;
        m_pend = 1'b1;
        step();
        sb.recal = 1'b0;
    endtask

    task automatic set_all(input int r);
        for (int p = 0; p < CH; p++) rise[p] = r;
    endtask

    task automatic check_reset_outputs();
        check("rst_cap_oe", cap_oe, 4'hF);
        check("rst_cap_out", cap_out & cap_oe, 0);
        check("rst_btn", sb.btn, 0);
        check("rst_cal_done", sb.cal_done, 0);
        check("rst_timeout_err", sb.timeout_err, 0);
    endtask

    task automatic release_reset();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        gap = 0;
    endtask

    initial begin
        sb.recal = 1'b0;
        events = 0;
        model_reset();
        set_all(40);
        #1 check_reset_outputs();
        release_reset();

        // Calibration sweep: every pad settles at 40.
        run_events(CH);
        check("cal_done_after_sweep", sb.cal_done, 1);

        // Threshold: 45 equals baseline+margin, 46 exceeds it.
        rise[2] = 45;
        run_events(CH * 5);
        check("btn_at_equal", sb.btn, 0);
        rise[2] = 46;
        run_events(CH * 3);
        check("btn2_before_4th", sb.btn[2], 0);
        run_events(CH);
        check("btn2_after_4th", sb.btn, 4'b0100);

        // Debounce: alternating samples hold, four quiet samples release.
        for (int k = 0; k < 6; k++) begin
            rise[2] = (k % 2 == 0) ? 40 : 46;
            run_events(CH);
        end
        check("btn2_held", sb.btn[2], 1);
        rise[2] = 40;
        run_events(CH * 3);
        check("btn2_still_held", sb.btn[2], 1);
        run_events(CH);
        check("btn2_released", sb.btn[2], 0);

        // Timeout on pad 1 while pad 2 is touched.
        rise[2] = 50;
        run_events(CH * 4);
        rise[1] = STUCK;
        run_events(2);
        check("timeout_pad1", sb.timeout_err, 4'b0010);
        rise[1] = 40;
        run_events(2);

        // Recal during pad 1 measure; new baselines of 60 give a threshold of 67.
        run_events(1);
        set_all(60);
        wait_measure(1);
        pulse_recal();
        run_events(1);
        check("recal_cal_done", sb.cal_done, 0);
        check("recal_terr", sb.timeout_err, 0);
        check("recal_btn_held", sb.btn, 4'b0100);
        run_events(CH);
        rise[2] = 60;
        rise[3] = 67;
        run_events(CH * 4);
        check("btn3_at_67", sb.btn[3], 0);
        rise[3] = 68;
        run_events(CH * 4);
        check("btn3_at_68", sb.btn, 4'b1000);

        // Reset in the middle of a measure.
        wait_measure(2);
        repeat (5) step();
        reset = 1'b0;
        model_reset();
        #1 check_reset_outputs();
        set_all(40);
        release_reset();
        run_events(CH);

        // Random rise times, occasional stuck pads and stray recal pulses.
        for (int s = 0; s < 25; s++) begin
            for (int p = 0; p < CH; p++) begin
                rise[p] = $urandom_range(55, 35);
                if ($urandom_range(15, 0) == 0) rise[p] = STUCK;
            end
            if ($urandom_range(7, 0) == 0) begin
                repeat ($urandom_range(60, 1)) step();
                pulse_recal();
            end
            run_events(CH);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cap_touch_scanner.md
CAP_TOUCH_SCANNER -- requirements
Module: cap_touch_scanner

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of touch pads, range 1..16.
REQ-002 SHALL have parameter CNT_W, default 15: width of the rise-time counter and of each stored baseline.
REQ-003 SHALL have parameter DISCHARGE_CYCLES, default 11: number of clock cycles each pad is held discharged before measurement.
REQ-004 SHALL have parameter THRESH_SHIFT, default 3: touch margin equals baseline >> THRESH_SHIFT.
REQ-005 SHALL have parameter DEBOUNCE, default 4: number of agreeing samples needed to change btn, range 2..8.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port cap_in, input, CHANNELS bits: pad sense inputs, asynchronous to clk.
REQ-009 SHALL have port cap_out, output, CHANNELS bits: pad drive; bit i is 0 when cap_oe[i]=1 and high-impedance otherwise.
REQ-010 SHALL have port cap_oe, output, CHANNELS bits: pad discharge enable.
REQ-011 SHALL have port recal, input, 1 bit: recalibration request, sampled every cycle.
REQ-012 SHALL have port btn, output, CHANNELS bits: debounced touch state per pad.
REQ-013 SHALL have port cal_done, output, 1 bit: high when a full calibration sweep is complete.
REQ-014 SHALL have port timeout_err, output, CHANNELS bits: sticky flag per pad, set when that pad's counter saturates.

Function
REQ-015 SHALL pass every cap_in bit through a two-flop synchroniser; all decisions SHALL use the synchronised value.
REQ-016 SHALL scan pads one at a time using index ch, in the order 0,1,..,CHANNELS-1, then wrap to 0.
REQ-017 SHALL hold cap_oe[i]=1 for every pad i that is not currently being measured.
REQ-018 SHALL run the FSM states DISCHARGE -> MEASURE -> (next ch) DISCHARGE, with a mode bit CAL or RUN.
REQ-019 In DISCHARGE, SHALL hold cap_oe[ch]=1 for exactly DISCHARGE_CYCLES cycles, then enter MEASURE with the counter at 0 and cap_oe[ch]=0.
REQ-020 In MEASURE, SHALL increment the counter each cycle the synchronised input is 0; the counter value in the first cycle it is 1 is the sample, and the FSM then advances ch and enters DISCHARGE.
REQ-021 SHALL, if the counter reaches 2^CNT_W-1 in MEASURE, set timeout_err[ch], take sample = 2^CNT_W-1 and advance (counter never wraps).
REQ-022 In CAL mode, SHALL store the sample into baseline[ch]; after storing for ch=CHANNELS-1, SHALL set cal_done=1 and switch to RUN.
REQ-023 In RUN mode, touched = sample > baseline + (baseline >> THRESH_SHIFT), computed at CNT_W+1 bits with no overflow; equality SHALL count as not touched.
REQ-024 In RUN mode, SHALL discard a timed-out sample and leave the debouncer unchanged.
REQ-025 SHALL shift touched into a per-pad DEBOUNCE-bit history; btn[ch] SHALL go to 1 when the history is all ones, to 0 when it is all zeros, and hold otherwise.
REQ-026 SHALL change btn only in the cycle after a RUN sample is taken, and only for that pad.
REQ-027 SHALL latch a recal pulse as pending; it SHALL act at the end of the current MEASURE (or immediately if the FSM is in DISCHARGE, after that discharge completes its measure).
REQ-028 When recal acts, SHALL set ch=0, mode=CAL, cal_done=0, clear all timeout_err bits, and hold btn and the debouncers unchanged.
REQ-029 A recal during CAL mode SHALL restart the sweep from ch=0.

Reset
REQ-030 While reset=0, SHALL force: mode=CAL, state=DISCHARGE, ch=0, counter=0, cap_oe all 1, btn=0, cal_done=0, timeout_err=0, baselines=0, debouncers=0, synchronisers=0, recal pending=0.
REQ-031 SHALL, on reset deassertion mid-scan, restart with a full calibration sweep; no partial measurement is kept.

Verification
REQ-032 Reset: assert reset=0 mid-MEASURE -> cap_oe=all 1, btn=0, cal_done=0, timeout_err=0 at once; after release, ch 0 is in DISCHARGE for 11 cycles.
REQ-033 Calibration: CHANNELS=4, pad model rises 40 cycles after release -> cal_done=1 after 4 pad periods and baseline=40 for each pad.
REQ-034 Threshold: baseline 40 gives margin 5; pad 2 samples of 46 four times -> btn[2]=1 after the 4th sample; samples of 45 never set btn; other btn bits stay 0.
REQ-035 Debounce: with btn[2]=1, samples alternate 40/46 -> btn[2] holds 1; four samples of 40 -> btn[2]=0.
REQ-036 Timeout: CNT_W=8, pad 1 held low -> counter stops at 255, timeout_err[1]=1, scan advances to pad 2, btn[1] unchanged.
REQ-037 Recal: pulse recal during pad 1 MEASURE -> pad 1 completes, then cal_done=0, timeout_err=0, ch=0 in CAL, btn held; new baselines are taken after the sweep.
